// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, flag register and conditional branch control
// Single RUN/HALT FSM; pc, flags and the taken/flush pulse are all registered.
module pc_branch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_in,
  input  logic        br_valid,
  input  logic        br_reg_mode,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_target,
  input  logic [15:0] br_reg,
  input  logic [2:0]  flag_wr,
  input  logic [2:0]  flag_in,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        taken,
  output logic        flush,
  output logic        halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        cond_true;
  logic        take;
  logic [15:0] br_dest;

  assign pc_plus2 = pc + 16'd2;
  assign flag_z   = flags[2];
  assign flag_v   = flags[1];
  assign flag_n   = flags[0];

  // Conditions look only at the registered flags, never at this cycle's flag_in.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || !flag_n;
      3'b101: cond_true = flag_z || flag_n;
      3'b110: cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign take    = br_valid && cond_true && (state == RUN) && !stall && !halt_in;
  assign br_dest = (br_reg_mode ? br_reg : br_target) & 16'hFFFE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= 16'h0000;
      flags  <= 3'b000;
      taken  <= 1'b0;
      flush  <= 1'b0;
      halted <= 1'b0;
    end else if (stall || state == HALT) begin
      taken <= 1'b0;
      flush <= 1'b0;
    end else begin
      flags <= (flags & ~flag_wr) | (flag_in & flag_wr);
      if (halt_in) begin
        // pc stays on the HLT address; a coincident branch is dropped
        state  <= HALT;
        halted <= 1'b1;
        taken  <= 1'b0;
        flush  <= 1'b0;
      end else if (take) begin
        pc    <= br_dest;
        taken <= 1'b1;
        flush <= 1'b1;
      end else begin
        pc    <= pc_plus2;
        taken <= 1'b0;
        flush <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - scoreboard bench for pc_branch_ctrl
// Directed scenarios followed by randomized traffic against a behavioural model.
module tb_pc_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_in;
  logic        br_valid;
  logic        br_reg_mode;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [15:0] br_reg;
  logic [2:0]  flag_wr;
  logic [2:0]  flag_in;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags;
  logic        taken;
  logic        flush;
  logic        halted;

  pc_branch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_in(halt_in),
    .br_valid(br_valid), .br_reg_mode(br_reg_mode), .br_cond(br_cond),
    .br_target(br_target), .br_reg(br_reg), .flag_wr(flag_wr), .flag_in(flag_in),
    .pc(pc), .pc_plus2(pc_plus2), .flags(flags), .taken(taken), .flush(flush),
    .halted(halted)
  );

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        taken;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] m_pc     = 16'h0000;
  logic [2:0]  m_flags  = 3'b000;
  bit          m_halted = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, pop the outcome the stimulus predicted for it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("pc_plus2", pc_plus2, e.pc + 16'd2);
      check("flags", {13'd0, flags}, {13'd0, e.flags});
      check("taken", {15'd0, taken}, {15'd0, e.taken});
      check("flush", {15'd0, flush}, {15'd0, e.taken});
      check("halted", {15'd0, halted}, {15'd0, e.halted});
    end
  end

  function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input logic r, input logic s, input logic h, input logic bv,
                      input logic bm, input logic [2:0] c, input logic [15:0] bt,
                      input logic [15:0] br, input logic [2:0] fw, input logic [2:0] fi);
    exp_t e;
    bit   tk;
    @(negedge clk);
    rst = r; stall = s; halt_in = h; br_valid = bv; br_reg_mode = bm;
    br_cond = c; br_target = bt; br_reg = br; flag_wr = fw; flag_in = fi;
    tk = 1'b0;
    if (r) begin
      m_pc = 16'h0000;
      m_flags = 3'b000;
      m_halted = 1'b0;
    end else if (!s && !m_halted) begin
      if (h) begin
        m_halted = 1'b1;
      end else if (bv && cond_holds(c, m_flags)) begin
        m_pc = bm ? {br[15:1], 1'b0} : {bt[15:1], 1'b0};
        tk = 1'b1;
      end else begin
        m_pc = m_pc + 16'd2;
      end
      for (int i = 0; i < 3; i++) if (fw[i]) m_flags[i] = fi[i];
    end
    e.pc = m_pc;
    e.flags = m_flags;
    e.taken = tk;
    e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 3'b000, 3'b000);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt_in = 1'b0; br_valid = 1'b0; br_reg_mode = 1'b0;
    br_cond = 3'd0; br_target = 16'h0; br_reg = 16'h0; flag_wr = 3'b0; flag_in = 3'b0;

    step(1, 1, 0, 1, 0, 3'd7, 16'h5555, 16'h0, 3'b111, 3'b111);
    repeat (3) idle();
    // conditional B with Z set, then NE which must fall through
    step(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 3'b100, 3'b100);
    step(0, 0, 0, 1, 0, 3'd1, 16'h0041, 16'h0, 3'b000, 3'b000);
    idle();
    step(0, 0, 0, 1, 0, 3'd0, 16'h0041, 16'h0, 3'b000, 3'b000);
    // flag hazard: same-cycle write of Z must not steer the branch
    step(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 3'b100, 3'b000);
    step(0, 0, 0, 1, 0, 3'd1, 16'h0200, 16'h0, 3'b100, 3'b100);
    step(0, 0, 0, 1, 0, 3'd1, 16'h0300, 16'h0, 3'b000, 3'b000);
    step(0, 0, 0, 1, 0, 3'd7, 16'h0400, 16'h0, 3'b000, 3'b000);
    // BR under stall, then released
    step(0, 1, 0, 1, 1, 3'd7, 16'h0, 16'h1234, 3'b111, 3'b111);
    step(0, 0, 0, 1, 1, 3'd7, 16'h0, 16'h1234, 3'b000, 3'b000);
    // halt with simultaneous taken branch, then frozen, then reset
    step(0, 0, 1, 1, 0, 3'd7, 16'h0800, 16'h0, 3'b010, 3'b010);
    repeat (5) step(0, 0, 1, 1, 0, 3'd7, 16'h0900, 16'h0, 3'b111, 3'b111);
    step(1, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 3'b000, 3'b000);
    idle();
    // wrap, with bit 0 of the register target forced low
    step(0, 0, 0, 1, 1, 3'd7, 16'h0, 16'hFFFF, 3'b000, 3'b000);
    idle();
    idle();

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 2,
           $urandom_range(99) < 50, 1'($urandom), 3'($urandom), 16'($urandom),
           16'($urandom), 3'($urandom), 3'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 16 bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, freeze all state this cycle.
REQ-005 SHALL have port halt_in, input, 1, decoded HLT instruction.
REQ-006 SHALL have port br_valid, input, 1, decoded branch (B or BR) present.
REQ-007 SHALL have port br_reg_mode, input, 1: 1 = BR (register target), 0 = B (adder target).
REQ-008 SHALL have port br_cond, input, 3, condition code.
REQ-009 SHALL have port br_target, input, 16, target from the branch-address adder.
REQ-010 SHALL have port br_reg, input, 16, register-file operand for BR.
REQ-011 SHALL have port flag_wr, input, 3, per-flag write enables {Z,V,N}.
REQ-012 SHALL have port flag_in, input, 3, new flag values {Z,V,N}.
REQ-013 SHALL have port pc, output, 16, current fetch address (registered).
REQ-014 SHALL have port pc_plus2, output, 16, pc + 2 (combinational, mod 2^16).
REQ-015 SHALL have port flags, output, 3, registered {Z,V,N}.
REQ-016 SHALL have port taken, output, 1, registered one-cycle pulse: branch taken last edge.
REQ-017 SHALL have port flush, output, 1, registered one-cycle pulse, equal to taken; squashes the wrong-path fetch.
REQ-018 SHALL have port halted, output, 1, high while in state HALT.

Function
REQ-019 SHALL implement states RUN and HALT; RUN->HALT on halt_in & !stall; HALT exits only via rst.
REQ-020 SHALL apply per-edge priority: rst > stall > HALT state > halt_in > taken branch > sequential (pc <= pc_plus2).
REQ-021 SHALL, with stall=1, hold pc, flags and state, and drive taken=flush=0 next cycle.
REQ-022 SHALL evaluate conditions on registered flags only (no bypass of the same-cycle flag_in): 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|N=0; 101 LTE Z=1|N=1; 110 OVFL V=1; 111 always.
REQ-023 SHALL treat branch as taken when br_valid & condition true & RUN & !stall & !halt_in.
REQ-024 SHALL, on a taken branch, load pc with br_reg if br_reg_mode=1 else br_target, with bit 0 forced to 0 in both cases.
REQ-025 SHALL set taken=flush=1 for exactly the cycle after a taken-branch edge; back-to-back taken branches give back-to-back pulses.
REQ-026 SHALL update each flag bit independently when its flag_wr bit is 1, while RUN and !stall, including in the same cycle as a branch (the branch uses the old flags).
REQ-027 SHALL freeze pc and flags in HALT, ignoring br_valid, halt_in and flag_wr.
REQ-028 SHALL wrap pc_plus2 from 0xFFFE to 0x0000 without error indication.
REQ-029 SHALL give halt_in priority over a simultaneous taken branch: pc holds the HLT address and taken stays 0.

Reset
REQ-030 SHALL, on the edge with rst=1, set pc=0x0000, flags=000, taken=0, flush=0, halted=0 and state=RUN, regardless of stall or state, including from HALT and mid-branch.
REQ-031 SHALL make the first fetch after rst deasserts at pc=0x0000, advancing to 0x0002 on the following edge.

Verification
REQ-032 SHALL cover sequential fetch: 3 edges after reset, no branch -> pc 0x0002, 0x0004, 0x0006; taken=0.
REQ-033 SHALL cover conditional B: write flags Z=1, then br_valid, cond=001, br_target=0x0041 -> pc=0x0040 and taken=flush=1 for 1 cycle; same with cond=000 -> pc=pc_plus2 and taken=0.
REQ-034 SHALL cover the flag hazard: flag_wr=100, flag_in Z=1 in the same cycle as cond=001 with old Z=0 -> not taken; next-cycle EQ -> taken.
REQ-035 SHALL cover BR and stall: br_reg_mode=1, br_reg=0x1234, cond=111 with stall=1 -> pc unchanged and taken=0; stall=0 -> pc=0x1234 and taken=1.
REQ-036 SHALL cover halt: halt_in with a simultaneous taken branch -> halted=1, pc frozen for 5 cycles, taken=0; then rst -> pc=0x0000 and halted=0.
REQ-037 SHALL cover wrap: pc=0xFFFE with no branch -> next pc=0x0000.
